// File: rtl/music_pkg.sv
// Shared constants and FSM encodings for the note scheduling path.
package music_pkg;

  localparam int NOTE_W    = 6;
  localparam int DUR_W     = 6;
  localparam int NOTE_REST = 0;
  localparam int BEAT_HZ   = 48;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/dffr.sv
// Generic state flops with synchronous active-low reset, plain and with enable.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register with synchronous clear
  always_ff @(posedge clk) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

endmodule

module dffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register with synchronous clear and load enable
  always_ff @(posedge clk) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
    else         q <= q;
  end

endmodule

// File: rtl/voice_counter.sv
// Per-voice remaining-beat down-counter with load priority and a done pulse.
module voice_counter #(
  parameter int DUR_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             beat_en,
  input  logic [DUR_W-1:0] dur,
  output logic [DUR_W-1:0] count,
  output logic             active,
  output logic             done
);

  localparam logic [DUR_W-1:0] ONE = DUR_W'(1);

  logic [DUR_W-1:0] count_next_s;
  logic             done_next_s;

  // Load beats decrement; a load in the same cycle swallows the beat and its done pulse
  always_comb begin
    count_next_s = count;
    done_next_s  = 1'b0;
    if (load) begin
      count_next_s = dur;
      done_next_s  = 1'b0;
    end else if (beat_en && (count != '0)) begin
      count_next_s = count - ONE;
      done_next_s  = (count == ONE);
    end else begin
      count_next_s = count;
      done_next_s  = 1'b0;
    end
  end

  dffr #(.W(DUR_W)) u_count (.clk(clk), .reset(reset), .d(count_next_s), .q(count));
  dffr #(.W(1))     u_done  (.clk(clk), .reset(reset), .d(done_next_s),  .q(done));

  assign active = (count != '0);

endmodule

// File: rtl/voice_allocator.sv
// Accepts notes from the song reader and assigns each to a free (or stolen) voice,
// issuing that voice's load strobe and tracking its remaining beats.
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = music_pkg::NOTE_W,
  parameter int DUR_W      = music_pkg::DUR_W,
  parameter bit STEAL_EN   = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play_enable,
  input  logic                         beat,
  input  logic                         note_valid,
  input  logic [NOTE_W-1:0]            note_in,
  input  logic [DUR_W-1:0]             dur_in,
  output logic                         note_ready,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES-1:0]        voice_done,
  output logic                         stolen
);
  import music_pkg::*;

  localparam int SEL_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int REQ_W = SEL_W + NOTE_W + DUR_W + 1;

  state_t                  state_s;
  state_t                  state_next_s;
  logic                    state_q_s;
  logic [DUR_W-1:0]        count_s [NUM_VOICES];
  logic                    free_found_s;
  logic [SEL_W-1:0]        free_idx_s;
  logic [SEL_W-1:0]        min_idx_s;
  logic [DUR_W-1:0]        min_cnt_s;
  logic [SEL_W-1:0]        pick_s;
  logic                    rest_in_s;
  logic                    ready_s;
  logic                    accept_s;
  logic                    beat_en_s;
  logic [NUM_VOICES-1:0]   load_s;
  logic [REQ_W-1:0]        req_r;
  logic [SEL_W-1:0]        sel_r;
  logic [NOTE_W-1:0]       note_r;
  logic [DUR_W-1:0]        dur_r;
  logic                    rest_r;

  // Free scan picks the lowest idle voice; the min scan is the steal candidate (ties to lower index)
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    min_idx_s    = '0;
    min_cnt_s    = count_s[0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!free_found_s && (count_s[i] == '0)) begin
        free_found_s = 1'b1;
        free_idx_s   = SEL_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
      if (count_s[i] < min_cnt_s) begin
        min_cnt_s = count_s[i];
        min_idx_s = SEL_W'(i);
      end else begin
        min_cnt_s = min_cnt_s;
      end
    end
    pick_s = free_found_s ? free_idx_s : min_idx_s;
  end

  assign rest_in_s = (note_in == NOTE_W'(NOTE_REST)) || (dur_in == '0);
  assign ready_s   = reset && (state_s == ST_IDLE) && play_enable && (free_found_s || STEAL_EN);
  assign accept_s  = note_valid && ready_s;
  assign beat_en_s = beat && play_enable;

  dffr #(.W(1)) u_state (.clk(clk), .reset(reset), .d(state_next_s), .q(state_q_s));
  assign state_s = state_t'(state_q_s);

  dffre #(.W(REQ_W)) u_req (
    .clk(clk), .reset(reset), .en(accept_s),
    .d({pick_s, note_in, dur_in, rest_in_s}), .q(req_r)
  );
  assign {sel_r, note_r, dur_r, rest_r} = req_r;

  // Next-state: one LOAD cycle after every accept
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_s)
      ST_IDLE: state_next_s = accept_s ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Load strobe: rests consume no voice, and a reset in the LOAD cycle kills the strobe
  always_comb begin
    load_s = '0;
    if (reset && (state_s == ST_LOAD) && !rest_r) begin
      load_s[sel_r] = 1'b1;
    end else begin
      load_s = '0;
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    voice_counter #(.DUR_W(DUR_W)) u_cnt (
      .clk(clk), .reset(reset), .load(load_s[i]), .beat_en(beat_en_s), .dur(dur_r),
      .count(count_s[i]), .active(voice_active[i]), .done(voice_done[i])
    );
    dffre #(.W(NOTE_W)) u_note (
      .clk(clk), .reset(reset), .en(load_s[i]), .d(note_r),
      .q(voice_note[i*NOTE_W +: NOTE_W])
    );
  end

  assign note_ready = ready_s;
  assign voice_load = load_s;
  assign stolen     = |(load_s & voice_active);

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: one stealing instance and one stalling instance.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset, play_enable, beat;
  logic        note_valid, note_valid2;
  logic [5:0]  note_in, dur_in, note_in2, dur_in2;
  logic        note_ready, note_ready2, stolen, stolen2;
  logic [2:0]  voice_load, voice_active, voice_done;
  logic [2:0]  voice_load2, voice_active2, voice_done2;
  logic [17:0] voice_note, voice_note2;

  int total = 0;
  int bad   = 0;

  voice_allocator #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6), .STEAL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat),
    .note_valid(note_valid), .note_in(note_in), .dur_in(dur_in),
    .note_ready(note_ready), .voice_load(voice_load), .voice_note(voice_note),
    .voice_active(voice_active), .voice_done(voice_done), .stolen(stolen)
  );

  voice_allocator #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6), .STEAL_EN(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat),
    .note_valid(note_valid2), .note_in(note_in2), .dur_in(dur_in2),
    .note_ready(note_ready2), .voice_load(voice_load2), .voice_note(voice_note2),
    .voice_active(voice_active2), .voice_done(voice_done2), .stolen(stolen2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    cyc();
    beat = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  // Offer one note and return in the LOAD cycle that follows the accept
  task automatic send(input bit ns, input logic [5:0] n, input logic [5:0] d);
    bit acc = 1'b0;
    if (ns) begin
      note_valid2 = 1'b1; note_in2 = n; dur_in2 = d;
    end else begin
      note_valid = 1'b1; note_in = n; dur_in = d;
    end
    #1;
    for (int k = 0; k < 20 && !acc; k++) begin
      if ((ns ? note_ready2 : note_ready) == 1'b1) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
      end else begin
        @(posedge clk);
        #2;
      end
    end
    note_valid  = 1'b0;
    note_valid2 = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; play_enable = 1'b1; beat = 1'b0;
    note_valid = 1'b0; note_in = 6'd0; dur_in = 6'd0;
    note_valid2 = 1'b0; note_in2 = 6'd0; dur_in2 = 6'd0;

    // 1. reset
    repeat (3) cyc();
    check("ready_in_reset", {31'd0, note_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("rst_load",   {29'd0, voice_load}, 32'd0);
    check("rst_note",   {14'd0, voice_note}, 32'd0);
    check("rst_active", {29'd0, voice_active}, 32'd0);
    check("rst_done",   {29'd0, voice_done}, 32'd0);
    check("rst_stolen", {31'd0, stolen}, 32'd0);
    check("rst_ready",  {31'd0, note_ready}, 32'd1);

    // 2. three notes onto three voices
    send(1'b0, 6'd20, 6'd4);
    check("load_v0", {29'd0, voice_load}, 32'b001);
    send(1'b0, 6'd25, 6'd4);
    check("load_v1", {29'd0, voice_load}, 32'b010);
    send(1'b0, 6'd30, 6'd4);
    check("load_v2", {29'd0, voice_load}, 32'b100);
    cyc();
    check("notes_3", {14'd0, voice_note}, {14'd0, 6'd30, 6'd25, 6'd20});
    check("active_3", {29'd0, voice_active}, 32'b111);
    repeat (3) pulse_beat();
    check("done_early", {29'd0, voice_done}, 32'b000);
    check("active_b3", {29'd0, voice_active}, 32'b111);
    pulse_beat();
    check("done_all", {29'd0, voice_done}, 32'b111);
    check("active_none", {29'd0, voice_active}, 32'b000);
    cyc();
    check("done_1cyc", {29'd0, voice_done}, 32'b000);

    // 3a. steal the voice with the fewest beats, counts {5,2,7}
    send(1'b0, 6'd10, 6'd5);
    send(1'b0, 6'd11, 6'd2);
    send(1'b0, 6'd12, 6'd7);
    cyc();
    send(1'b0, 6'd40, 6'd3);
    check("steal_load", {29'd0, voice_load}, 32'b010);
    check("steal_flag", {31'd0, stolen}, 32'd1);
    cyc();
    check("steal_note", {26'd0, voice_note[11:6]}, 32'd40);

    // 4. no stealing: stall until voice 2 finishes
    send(1'b1, 6'd1, 6'd5);
    send(1'b1, 6'd2, 6'd4);
    send(1'b1, 6'd3, 6'd2);
    cyc();
    note_valid2 = 1'b1; note_in2 = 6'd50; dur_in2 = 6'd6;
    #1;
    check("ns_ready_busy", {31'd0, note_ready2}, 32'd0);
    pulse_beat();
    check("ns_ready_b1", {31'd0, note_ready2}, 32'd0);
    check("ns_done_b1", {29'd0, voice_done2}, 32'b000);
    pulse_beat();
    check("ns_done_v2", {29'd0, voice_done2}, 32'b100);
    check("ns_ready_free", {31'd0, note_ready2}, 32'd1);
    cyc();
    note_valid2 = 1'b0;
    check("ns_load_v2", {29'd0, voice_load2}, 32'b100);
    check("ns_stolen", {31'd0, stolen2}, 32'd0);
    cyc();

    // 3b. ties {3,3,3} steal voice 0
    do_reset();
    send(1'b0, 6'd1, 6'd3);
    send(1'b0, 6'd2, 6'd3);
    send(1'b0, 6'd3, 6'd3);
    cyc();
    send(1'b0, 6'd41, 6'd2);
    check("tie_load", {29'd0, voice_load}, 32'b001);
    check("tie_stolen", {31'd0, stolen}, 32'd1);
    cyc();
    check("tie_note", {26'd0, voice_note[5:0]}, 32'd41);

    // 5. rest and zero duration consume no voice; counts now {2,3,3}
    send(1'b0, 6'd0, 6'd8);
    check("rest_load", {29'd0, voice_load}, 32'b000);
    check("rest_stolen", {31'd0, stolen}, 32'd0);
    cyc();
    send(1'b0, 6'd12, 6'd0);
    check("zdur_load", {29'd0, voice_load}, 32'b000);
    cyc();
    check("rest_active", {29'd0, voice_active}, 32'b111);
    check("rest_notes", {14'd0, voice_note}, {14'd0, 6'd3, 6'd2, 6'd41});
    pulse_beat();
    check("rest_b1_done", {29'd0, voice_done}, 32'b000);
    pulse_beat();
    check("rest_b2_done", {29'd0, voice_done}, 32'b001);
    check("rest_b2_active", {29'd0, voice_active}, 32'b110);
    pulse_beat();
    check("rest_b3_done", {29'd0, voice_done}, 32'b110);

    // 6a. beat coincident with LOAD: load wins
    send(1'b0, 6'd15, 6'd3);
    check("coin_load", {29'd0, voice_load}, 32'b001);
    pulse_beat();
    check("coin_active", {29'd0, voice_active}, 32'b001);
    pulse_beat();
    pulse_beat();
    check("coin_b2_done", {29'd0, voice_done}, 32'b000);
    check("coin_b2_active", {29'd0, voice_active}, 32'b001);
    pulse_beat();
    check("coin_b3_done", {29'd0, voice_done}, 32'b001);

    // 6b. pause freezes counters and ready
    send(1'b0, 6'd16, 6'd2);
    check("pause_load", {29'd0, voice_load}, 32'b001);
    cyc();
    play_enable = 1'b0;
    #1;
    check("pause_ready", {31'd0, note_ready}, 32'd0);
    repeat (10) pulse_beat();
    check("pause_active", {29'd0, voice_active}, 32'b001);
    check("pause_done", {29'd0, voice_done}, 32'b000);
    play_enable = 1'b1;
    pulse_beat();
    check("resume_b1", {29'd0, voice_done}, 32'b000);
    pulse_beat();
    check("resume_b2", {29'd0, voice_done}, 32'b001);

    // 6c. LOAD in flight completes while paused
    send(1'b0, 6'd17, 6'd1);
    play_enable = 1'b0;
    #1;
    check("flight_load", {29'd0, voice_load}, 32'b001);
    cyc();
    check("flight_active", {29'd0, voice_active}, 32'b001);
    play_enable = 1'b1;

    // 6d. reset during LOAD
    send(1'b0, 6'd18, 6'd2);
    check("mid_load_pre", {29'd0, voice_load}, 32'b010);
    reset = 1'b0;
    #1;
    check("mid_load_strobe", {29'd0, voice_load}, 32'b000);
    check("mid_load_ready", {31'd0, note_ready}, 32'd0);
    cyc();
    check("mid_active", {29'd0, voice_active}, 32'b000);
    check("mid_note", {14'd0, voice_note}, 32'd0);
    check("mid_done", {29'd0, voice_done}, 32'b000);
    check("mid_stolen", {31'd0, stolen}, 32'd0);
    reset = 1'b1;
    #1;
    check("post_ready", {31'd0, note_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
